mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle sequencing controller for the MIPS datapath. It decodes the current instruction register fields and steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB. Each state drives the datapath's write enables and mux selects. Memory accesses go through one unified memory port with a req/ack handshake. It replaces purely combinational control when instruction and data memory are shared.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag, valid in EXEC
- mem_ack  in  1  memory completes the request this cycle
- mem_req  out  1  memory request strobe
- mem_we  out  1  request is a write
- mem_size  out  2  access size: 0 word, 1 byte, 2 half
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_src  out  2  PC source: 0 PC+4, 1 branch target, 2 jump imm26, 3 rs
- reg_we  out  1  register file write
- reg_dst  out  2  write register: 0 rt, 1 rd, 2 $31
- wd_sel  out  2  write data: 0 ALU, 1 memory data, 2 PC
- alu_src  out  1  ALU B operand: 0 reg, 1 extended imm
- alu_op  out  4  ALU function: 0 add, 1 sub, 2 or
- ext_op  out  2  immediate extension: 0 zero, 1 lui, 2 sign
- instr_done  out  1  one-cycle pulse on instruction retirement
- state  out  3  current FSM state, debug only
- cycle_cnt  out  32  performance counter, see Configuration
- instr_cnt  out  32  performance counter, see Configuration

## Operation
Instruction classes:
- R: addu, subu
- I: ori, lui
- LD: lw, lbu, lhu
- ST: sw, sb, sh
- BR: beq, bne
- J: j, jal, jr, jalr
- Any other op/funct is NOP: retired from DECODE.

States (encoding 0..4): FETCH, DECODE, EXEC, MEM, WB. Transitions:
- **FETCH**
  - mem_req=1, mem_we=0, mem_size=0.
  - On mem_ack: ir_we=1, pc_we=1 with pc_src=0, then go to DECODE.
  - Without mem_ack: hold FETCH.
- **DECODE**
  - j: pc_we with pc_src=2, retire, go to FETCH.
  - jr: pc_we with pc_src=3, retire, go to FETCH.
  - jal, jalr: go to WB.
  - NOP: retire, go to FETCH.
  - All other classes: go to EXEC.
- **EXEC**
  - ALU fields are driven from decode.
  - BR: if beq&zero or bne&!zero, pc_we with pc_src=1. Retire, go to FETCH.
  - LD, ST: go to MEM.
  - R, I: go to WB.
- **MEM**
  - mem_req=1, mem_we=ST, mem_size from opcode.
  - Hold until mem_ack.
  - LD goes to WB. ST retires and goes to FETCH.
- **WB**
  - reg_we=1 for one cycle, then retire and go to FETCH.
  - jal: reg_dst=2, wd_sel=2, plus pc_we with pc_src=2 in the same cycle. The register file captures the pre-update PC (already PC+4).
  - jalr: reg_dst=1, wd_sel=2, plus pc_we with pc_src=3.

Rules:
- "Retire" means instr_done=1 for one cycle.
- Strobes (mem_req, ir_we, pc_we, reg_we, instr_done) are Moore/Mealy combinations of state, decode and mem_ack. Each is high only in the state listed above.
- Select fields outside their use state are don't-care. They are driven to 0.
- op/funct are sampled only in DECODE or later; values seen in FETCH are ignored.

## Timing
- Reset: state=FETCH. All strobes and selects are 0; counters are 0.
- Reset asserted mid-instruction aborts it immediately. No retirement is counted.
- mem_ack is accepted in the same cycle mem_req rises, so zero-wait memory gives single-cycle FETCH/MEM.
- mem_ack while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory:
  - 2: j, jr, NOP
  - 3: jal, jalr, BR
  - 4: R, I, ST
  - 5: LD
- Each memory wait cycle adds 1.

## Configuration
Macro `MC_PERF_CNT_EN`.
- **Defined:**
  - cycle_cnt increments every clock out of reset.
  - instr_cnt increments on each instr_done.
  - Both are 32-bit and wrap at 2^32 to 0.
- **Undefined:** both ports are driven constant 0 and no counter flops are synthesised.

## Structure
- Package mc_pkg holds:
  - State encodings.
  - Opcode/funct constants.
  - pc_src, reg_dst, wd_sel, alu_op, ext_op and mem_size codes.
- Sub-module mc_decode: combinational op/funct to class one-hot plus alu_op/ext_op/alu_src/mem_size/reg_dst.
- mc_controller instantiates mc_decode and holds the FSM and counters.

## Test plan
- addu with mem_ack tied 1:
  - States run FETCH, DECODE, EXEC, WB, FETCH.
  - reg_we=1, reg_dst=1 only in cycle 4; instr_done in cycle 4.
- lw with mem_ack delayed 3 cycles in MEM:
  - MEM lasts 4 cycles; WB has wd_sel=1.
  - Total 8 cycles; cycle_cnt=8, instr_cnt=1 with the macro.
- beq with zero=1, then bne with zero=1:
  - First: pc_we=1, pc_src=1 in EXEC.
  - Second: pc_we stays 0; both take 3 cycles.
- jal:
  - WB asserts reg_we, reg_dst=2, wd_sel=2, pc_we, pc_src=2 together.
  - jr asserts pc_we, pc_src=3 in DECODE.
- Unknown op 6'b111111: retires from DECODE after 2 cycles with no reg_we/mem_req.
- Reset in MEM mid-sw: mem_req drops immediately and state=FETCH. instr_cnt is not incremented.

Source files
------------

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle MIPS sequencing controller:
//   - FSM state encoding (FETCH..WB = 0..4)
//   - opcode / funct constants for the supported instructions
//   - select-field codes for pc_src, reg_dst, wd_sel, alu_op, ext_op, mem_size
//   - dec_t: the decoded instruction record passed from mc_decode to the FSM
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
  localparam logic [1:0] PC_SRC_BR   = 2'd1;
  localparam logic [1:0] PC_SRC_JIMM = 2'd2;
  localparam logic [1:0] PC_SRC_RS   = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_LUI  = 2'd1;
  localparam logic [1:0] EXT_SIGN = 2'd2;

  localparam logic [1:0] MEM_WORD = 2'd0;
  localparam logic [1:0] MEM_BYTE = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;

  // One-hot instruction class plus the static datapath fields for it.
  // brNe distinguishes bne from beq inside the BR class.
  typedef struct packed {
    logic       isR;
    logic       isI;
    logic       isLd;
    logic       isSt;
    logic       isBr;
    logic       brNe;
    logic       isJ;
    logic       isJr;
    logic       isJal;
    logic       isJalr;
    logic       isNop;
    logic       aluSrc;
    logic [3:0] aluOp;
    logic [1:0] extOp;
    logic [1:0] memSize;
    logic [1:0] regDst;
  } dec_t;

  // Branch resolution: beq takes on zero, bne takes on not-zero.
  function automatic logic brTaken(input dec_t d, input logic zero);
    return d.isBr & (d.brNe ? ~zero : zero);
  endfunction

endpackage

// File: rtl/mc_if.sv
// -----------------------------------------------------------------------------
// mc_if
// Bundle between the sequencing controller and the datapath/memory.
//   Datapath -> controller : op, funct, zero, mem_ack
//   Controller -> datapath : memory strobe/size, write enables, mux selects,
//                            ALU controls, instr_done, debug state, counters
// modport master : the controller side
// modport slave  : the datapath side
// -----------------------------------------------------------------------------
interface mc_if;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic [1:0]  ext_op;
  logic        instr_done;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  modport master (
    input  op, funct, zero, mem_ack,
    output mem_req, mem_we, mem_size, ir_we, pc_we, pc_src, reg_we,
           reg_dst, wd_sel, alu_src, alu_op, ext_op, instr_done, state,
           cycle_cnt, instr_cnt
  );

  modport slave (
    output op, funct, zero, mem_ack,
    input  mem_req, mem_we, mem_size, ir_we, pc_we, pc_src, reg_we,
           reg_dst, wd_sel, alu_src, alu_op, ext_op, instr_done, state,
           cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Purely combinational instruction decoder.
//   i_op    : IR[31:26]
//   i_funct : IR[5:0]
//   o_dec   : class one-hot plus alu_op/ext_op/alu_src/mem_size/reg_dst
// Anything not recognised decodes as NOP.
// -----------------------------------------------------------------------------
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  // Map opcode/funct onto a class and its fixed datapath controls.
  // lui uses OR with rs (encoded as $0) so the ALU just passes the
  // shifted immediate through.
  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: begin
            o_dec.isR    = 1'b1;
            o_dec.aluOp  = ALU_ADD;
            o_dec.regDst = REG_DST_RD;
          end
          FN_SUBU: begin
            o_dec.isR    = 1'b1;
            o_dec.aluOp  = ALU_SUB;
            o_dec.regDst = REG_DST_RD;
          end
          FN_JR:   o_dec.isJr = 1'b1;
          FN_JALR: begin
            o_dec.isJalr = 1'b1;
            o_dec.regDst = REG_DST_RD;
          end
          default: o_dec.isNop = 1'b1;
        endcase
      end
      OP_ORI, OP_LUI: begin
        o_dec.isI    = 1'b1;
        o_dec.aluSrc = 1'b1;
        o_dec.aluOp  = ALU_OR;
        o_dec.extOp  = (i_op == OP_LUI) ? EXT_LUI : EXT_ZERO;
        o_dec.regDst = REG_DST_RT;
      end
      OP_LW, OP_LBU, OP_LHU: begin
        o_dec.isLd    = 1'b1;
        o_dec.aluSrc  = 1'b1;
        o_dec.aluOp   = ALU_ADD;
        o_dec.extOp   = EXT_SIGN;
        o_dec.regDst  = REG_DST_RT;
        o_dec.memSize = (i_op == OP_LBU) ? MEM_BYTE :
                        (i_op == OP_LHU) ? MEM_HALF : MEM_WORD;
      end
      OP_SW, OP_SB, OP_SH: begin
        o_dec.isSt    = 1'b1;
        o_dec.aluSrc  = 1'b1;
        o_dec.aluOp   = ALU_ADD;
        o_dec.extOp   = EXT_SIGN;
        o_dec.memSize = (i_op == OP_SB) ? MEM_BYTE :
                        (i_op == OP_SH) ? MEM_HALF : MEM_WORD;
      end
      OP_BEQ, OP_BNE: begin
        o_dec.isBr  = 1'b1;
        o_dec.brNe  = (i_op == OP_BNE);
        o_dec.aluOp = ALU_SUB;
        o_dec.extOp = EXT_SIGN;
      end
      OP_J:    o_dec.isJ = 1'b1;
      OP_JAL: begin
        o_dec.isJal  = 1'b1;
        o_dec.regDst = REG_DST_RA;
      end
      default: o_dec.isNop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multi-cycle sequencing controller for a shared-memory MIPS datapath.
// Steps FETCH -> DECODE -> EXEC -> MEM -> WB as the instruction needs and
// drives the datapath strobes and selects for each state.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mc_if.master (IR fields, zero flag, memory handshake, controls,
//           instr_done, debug state, performance counters)
// Build option: `MC_PERF_CNT_EN adds 32-bit cycle/instruction counters;
// without it cycle_cnt and instr_cnt are constant 0.
// -----------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  dec_t       w_dec;
  logic       w_memReq;
  logic       w_memWe;
  logic [1:0] w_memSize;
  logic       w_irWe;
  logic       w_pcWe;
  logic [1:0] w_pcSrc;
  logic       w_regWe;
  logic [1:0] w_regDst;
  logic [1:0] w_wdSel;
  logic       w_aluSrc;
  logic [3:0] w_aluOp;
  logic [1:0] w_extOp;
  logic       w_instrDone;

  mc_decode u_decode (
    .i_op    (bus.op),
    .i_funct (bus.funct),
    .o_dec   (w_dec)
  );

  // State register; reset drops straight back to FETCH, abandoning any
  // instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and output decode. Every output is forced low while reset
  // is asserted so nothing (notably mem_req in FETCH) leaks out during
  // reset. Decode results are only consulted from DECODE onward, which is
  // what makes the IR contents seen during FETCH irrelevant.
  always_comb begin
    w_next      = r_state;
    w_memReq    = 1'b0;
    w_memWe     = 1'b0;
    w_memSize   = MEM_WORD;
    w_irWe      = 1'b0;
    w_pcWe      = 1'b0;
    w_pcSrc     = PC_SRC_SEQ;
    w_regWe     = 1'b0;
    w_regDst    = REG_DST_RT;
    w_wdSel     = WD_ALU;
    w_aluSrc    = 1'b0;
    w_aluOp     = ALU_ADD;
    w_extOp     = EXT_ZERO;
    w_instrDone = 1'b0;
    if (reset) begin
      case (r_state)
        ST_FETCH: begin
          w_memReq = 1'b1;
          if (bus.mem_ack) begin
            w_irWe  = 1'b1;
            w_pcWe  = 1'b1;
            w_pcSrc = PC_SRC_SEQ;
            w_next  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_dec.isJ) begin
            w_pcWe      = 1'b1;
            w_pcSrc     = PC_SRC_JIMM;
            w_instrDone = 1'b1;
            w_next      = ST_FETCH;
          end else if (w_dec.isJr) begin
            w_pcWe      = 1'b1;
            w_pcSrc     = PC_SRC_RS;
            w_instrDone = 1'b1;
            w_next      = ST_FETCH;
          end else if (w_dec.isJal || w_dec.isJalr) begin
            w_next = ST_WB;
          end else if (w_dec.isNop) begin
            w_instrDone = 1'b1;
            w_next      = ST_FETCH;
          end else begin
            w_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          w_aluSrc = w_dec.aluSrc;
          w_aluOp  = w_dec.aluOp;
          w_extOp  = w_dec.extOp;
          if (w_dec.isBr) begin
            if (brTaken(w_dec, bus.zero)) begin
              w_pcWe  = 1'b1;
              w_pcSrc = PC_SRC_BR;
            end
            w_instrDone = 1'b1;
            w_next      = ST_FETCH;
          end else if (w_dec.isLd || w_dec.isSt) begin
            w_next = ST_MEM;
          end else if (w_dec.isR || w_dec.isI) begin
            w_next = ST_WB;
          end else begin
            w_next = ST_FETCH;
          end
        end
        ST_MEM: begin
          w_memReq  = 1'b1;
          w_memWe   = w_dec.isSt;
          w_memSize = w_dec.memSize;
          if (bus.mem_ack) begin
            if (w_dec.isSt) begin
              w_instrDone = 1'b1;
              w_next      = ST_FETCH;
            end else begin
              w_next = ST_WB;
            end
          end
        end
        ST_WB: begin
          // jal/jalr write the link value (PC already advanced by 4) in the
          // same cycle the PC is redirected.
          w_regWe     = 1'b1;
          w_regDst    = w_dec.regDst;
          w_wdSel     = w_dec.isLd ? WD_MEM :
                        (w_dec.isJal || w_dec.isJalr) ? WD_PC : WD_ALU;
          w_instrDone = 1'b1;
          w_next      = ST_FETCH;
          if (w_dec.isJal) begin
            w_pcWe  = 1'b1;
            w_pcSrc = PC_SRC_JIMM;
          end else if (w_dec.isJalr) begin
            w_pcWe  = 1'b1;
            w_pcSrc = PC_SRC_RS;
          end
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

  assign bus.mem_req    = w_memReq;
  assign bus.mem_we     = w_memWe;
  assign bus.mem_size   = w_memSize;
  assign bus.ir_we      = w_irWe;
  assign bus.pc_we      = w_pcWe;
  assign bus.pc_src     = w_pcSrc;
  assign bus.reg_we     = w_regWe;
  assign bus.reg_dst    = w_regDst;
  assign bus.wd_sel     = w_wdSel;
  assign bus.alu_src    = w_aluSrc;
  assign bus.alu_op     = w_aluOp;
  assign bus.ext_op     = w_extOp;
  assign bus.instr_done = w_instrDone;
  assign bus.state      = r_state;

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instrCnt;

  // Free-running performance counters, both wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycleCnt <= '0;
      r_instrCnt <= '0;
    end else begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
      if (w_instrDone) r_instrCnt <= r_instrCnt + 32'd1;
    end
  end

  assign bus.cycle_cnt = r_cycleCnt;
  assign bus.instr_cnt = r_instrCnt;
`else
  assign bus.cycle_cnt = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Self-checking bench for mc_controller. A reference model builds, from the
// instruction class rules, the expected per-cycle output trace for each
// instruction (including memory wait cycles) and the bench compares the DUT
// against it cycle by cycle, plus CPI and counter checks.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mc_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       memReq;
    logic       memWe;
    logic [1:0] memSize;
    logic       irWe;
    logic       pcWe;
    logic [1:0] pcSrc;
    logic       regWe;
    logic [1:0] regDst;
    logic [1:0] wdSel;
    logic       aluSrc;
    logic [3:0] aluOp;
    logic [1:0] extOp;
    logic       instrDone;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    bit    ack;
    bit    realIr;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    int         fw;
    int         mw;
    int         cpi;
  } vec_t;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_J = 5, C_JR = 6, C_JAL = 7, C_JALR = 8, C_NOP = 9;

  int    vecCount  = 0;
  int    missCount = 0;
  int    totCycles = 0;
  int    totInstr  = 0;
  step_t trace[$];
  vec_t  vecs[$];

  // Snapshot of every DUT control output in one packed record.
  function automatic outs_t getOuts();
    outs_t o;
    o.memReq    = bus.mem_req;
    o.memWe     = bus.mem_we;
    o.memSize   = bus.mem_size;
    o.irWe      = bus.ir_we;
    o.pcWe      = bus.pc_we;
    o.pcSrc     = bus.pc_src;
    o.regWe     = bus.reg_we;
    o.regDst    = bus.reg_dst;
    o.wdSel     = bus.wd_sel;
    o.aluSrc    = bus.alu_src;
    o.aluOp     = bus.alu_op;
    o.extOp     = bus.ext_op;
    o.instrDone = bus.instr_done;
    o.state     = bus.state;
    return o;
  endfunction

  // Instruction class straight from the MIPS encodings.
  function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00: begin
        case (funct)
          6'h21, 6'h23: return C_R;
          6'h08:        return C_JR;
          6'h09:        return C_JALR;
          default:      return C_NOP;
        endcase
      end
      6'h02:               return C_J;
      6'h03:               return C_JAL;
      6'h04, 6'h05:        return C_BR;
      6'h0D, 6'h0F:        return C_I;
      6'h23, 6'h24, 6'h25: return C_LD;
      6'h28, 6'h29, 6'h2B: return C_ST;
      default:             return C_NOP;
    endcase
  endfunction

  task automatic pushStep(input bit ack, input bit realIr, input outs_t e);
    step_t s;
    s.ack    = ack;
    s.realIr = realIr;
    s.exp    = e;
    trace.push_back(s);
  endtask

  // Reference model: expected cycle trace for one instruction. Non-memory
  // cycles carry a random mem_ack which the DUT must ignore.
  task automatic buildTrace(input logic [5:0] op, input logic [5:0] funct,
                            input bit zero, input int fw, input int mw);
    int         c;
    outs_t      e;
    logic [1:0] sz;
    c = classify(op, funct);
    trace.delete();
    for (int i = 0; i < fw; i++) begin
      e = '0; e.memReq = 1'b1;
      pushStep(1'b0, 1'b0, e);
    end
    e = '0; e.memReq = 1'b1; e.irWe = 1'b1; e.pcWe = 1'b1;
    pushStep(1'b1, 1'b0, e);

    e = '0; e.state = 3'd1;
    if (c == C_J)   begin e.pcWe = 1'b1; e.pcSrc = 2'd2; e.instrDone = 1'b1; end
    if (c == C_JR)  begin e.pcWe = 1'b1; e.pcSrc = 2'd3; e.instrDone = 1'b1; end
    if (c == C_NOP) e.instrDone = 1'b1;
    pushStep(1'($urandom_range(0, 1)), 1'b1, e);

    if (c == C_R || c == C_I || c == C_LD || c == C_ST || c == C_BR) begin
      e = '0; e.state = 3'd2;
      case (c)
        C_R: e.aluOp = (funct == 6'h23) ? 4'd1 : 4'd0;
        C_I: begin
          e.aluSrc = 1'b1; e.aluOp = 4'd2;
          e.extOp  = (op == 6'h0F) ? 2'd1 : 2'd0;
        end
        C_LD, C_ST: begin e.aluSrc = 1'b1; e.aluOp = 4'd0; e.extOp = 2'd2; end
        default: begin
          e.aluOp = 4'd1; e.extOp = 2'd2; e.instrDone = 1'b1;
          if ((op == 6'h04) ? zero : !zero) begin e.pcWe = 1'b1; e.pcSrc = 2'd1; end
        end
      endcase
      pushStep(1'($urandom_range(0, 1)), 1'b1, e);
    end

    if (c == C_LD || c == C_ST) begin
      sz = (op == 6'h24 || op == 6'h28) ? 2'd1 :
           (op == 6'h25 || op == 6'h29) ? 2'd2 : 2'd0;
      e = '0; e.state = 3'd3; e.memReq = 1'b1; e.memWe = (c == C_ST); e.memSize = sz;
      for (int i = 0; i < mw; i++) pushStep(1'b0, 1'b1, e);
      e.instrDone = (c == C_ST);
      pushStep(1'b1, 1'b1, e);
    end

    if (c == C_R || c == C_I || c == C_LD || c == C_JAL || c == C_JALR) begin
      e = '0; e.state = 3'd4; e.regWe = 1'b1; e.instrDone = 1'b1;
      e.regDst = (c == C_R || c == C_JALR) ? 2'd1 : (c == C_JAL) ? 2'd2 : 2'd0;
      e.wdSel  = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
      if (c == C_JAL)  begin e.pcWe = 1'b1; e.pcSrc = 2'd2; end
      if (c == C_JALR) begin e.pcWe = 1'b1; e.pcSrc = 2'd3; end
      pushStep(1'($urandom_range(0, 1)), 1'b1, e);
    end
  endtask

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h want %h (req/we/sz/ir/pcwe/pcsrc/regwe/dst/wd/asrc/aop/ext/done/st)",
               name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef MC_PERF_CNT_EN
    checkValue({tag, " cycle_cnt"}, bus.cycle_cnt, totCycles);
    checkValue({tag, " instr_cnt"}, bus.instr_cnt, totInstr);
`else
    checkValue({tag, " cycle_cnt"}, bus.cycle_cnt, 32'd0);
    checkValue({tag, " instr_cnt"}, bus.instr_cnt, 32'd0);
`endif
  endtask

  // Holds reset for two cycles with hostile inputs, checks everything is
  // quiet, then releases reset on a falling edge.
  task automatic applyReset();
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    bus.zero    = 1'b1;
    bus.op      = 6'h23;
    bus.funct   = 6'h21;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset outputs", getOuts(), '0);
    totCycles = 0;
    totInstr  = 0;
    checkCounters("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one instruction from a falling edge, checking every cycle; stops
  // early after maxSteps cycles when maxSteps >= 0 (no retirement counted).
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input bit zero, input int fw, input int mw,
                               input int maxSteps, input string tag,
                               output int doneAt);
    int n;
    buildTrace(op, funct, zero, fw, mw);
    n = (maxSteps >= 0 && maxSteps < trace.size()) ? maxSteps : trace.size();
    doneAt = -1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ack = trace[i].ack;
      bus.zero    = zero;
      bus.op      = trace[i].realIr ? op    : 6'($urandom);
      bus.funct   = trace[i].realIr ? funct : 6'($urandom);
      #1;
      if (i == 0) checkCounters(tag);
      checkOutput($sformatf("%s op=%h fn=%h cyc%0d", tag, op, funct, i + 1),
                  getOuts(), trace[i].exp);
      if (bus.instr_done === 1'b1 && doneAt < 0) doneAt = i + 1;
      @(negedge clk);
      totCycles++;
    end
    if (n == trace.size()) totInstr++;
  endtask

  initial begin
    int         doneAt;
    logic [5:0] op;
    logic [5:0] funct;
    logic [5:0] legalOps [15];
    logic [5:0] rFuncts [4];
    legalOps = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0D,
                 6'h0F, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    rFuncts  = '{6'h21, 6'h23, 6'h08, 6'h09};

    vecs.push_back('{6'h23, 6'h00, 1'b0, 0, 3, 5});
    vecs.push_back('{6'h00, 6'h21, 1'b0, 0, 0, 4});
    vecs.push_back('{6'h00, 6'h23, 1'b1, 1, 0, 4});
    vecs.push_back('{6'h0D, 6'h15, 1'b0, 0, 0, 4});
    vecs.push_back('{6'h0F, 6'h00, 1'b0, 2, 0, 4});
    vecs.push_back('{6'h24, 6'h00, 1'b0, 2, 1, 5});
    vecs.push_back('{6'h25, 6'h00, 1'b1, 0, 0, 5});
    vecs.push_back('{6'h2B, 6'h00, 1'b0, 1, 2, 4});
    vecs.push_back('{6'h28, 6'h00, 1'b0, 0, 0, 4});
    vecs.push_back('{6'h29, 6'h00, 1'b0, 0, 1, 4});
    vecs.push_back('{6'h04, 6'h00, 1'b1, 0, 0, 3});
    vecs.push_back('{6'h05, 6'h00, 1'b1, 0, 0, 3});
    vecs.push_back('{6'h04, 6'h00, 1'b0, 0, 0, 3});
    vecs.push_back('{6'h05, 6'h00, 1'b0, 1, 0, 3});
    vecs.push_back('{6'h02, 6'h00, 1'b0, 0, 0, 2});
    vecs.push_back('{6'h03, 6'h00, 1'b0, 0, 0, 3});
    vecs.push_back('{6'h00, 6'h08, 1'b0, 0, 0, 2});
    vecs.push_back('{6'h00, 6'h09, 1'b0, 1, 0, 3});
    vecs.push_back('{6'h3F, 6'h00, 1'b0, 0, 0, 2});
    vecs.push_back('{6'h00, 6'h20, 1'b0, 0, 0, 2});

    $display("[TB] start");
    applyReset();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, vecs[k].funct, vecs[k].zero, vecs[k].fw,
                    vecs[k].mw, -1, $sformatf("vec%0d", k), doneAt);
      checkValue($sformatf("vec%0d retire cycle", k), doneAt,
                 vecs[k].cpi + vecs[k].fw + vecs[k].mw);
    end
    #1;
    checkCounters("after table");

    // sw aborted by reset while waiting in MEM.
    applyStimulus(6'h2B, 6'h00, 1'b0, 0, 5, 4, "abort sw", doneAt);
    bus.mem_ack = 1'b0;
    #1;
    checkValue("abort pre mem_req", bus.mem_req, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    checkValue("abort mem_req", bus.mem_req, 1'b0);
    checkValue("abort state", bus.state, 3'd0);
    totCycles = 0;
    totInstr  = 0;
    checkCounters("abort");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(6'h00, 6'h21, 1'b0, 0, 0, -1, "post abort", doneAt);
    checkValue("post abort retire cycle", doneAt, 4);

    for (int k = 0; k < 150; k++) begin
      op = legalOps[$urandom_range(0, 14)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      funct = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 4) != 0) funct = rFuncts[$urandom_range(0, 3)];
      applyStimulus(op, funct, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 3), -1, $sformatf("rnd%0d", k), doneAt);
    end
    #1;
    checkCounters("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
